// File: rtl/music_score_sequencer.sv
// Score sequencer: fetches key/duration pairs, times notes with a tempo prescaler.
// Define MUSIC_SCORE_LOOP_EN to repeat the score from StartAddress at each zero key.
module music_score_sequencer #(
    parameter int AddressBits = 5,
    parameter int DataLength  = 4,
    parameter int TimeBits    = 4,
    parameter int TickDivide  = 50000,
    parameter int GapCycles   = 1000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stop,
    input  logic                   Pause,
    input  logic [AddressBits-1:0] StartAddress,
    input  logic [DataLength-1:0]  KeyInput,
    input  logic [TimeBits-1:0]    TimeInput,
    output logic [AddressBits-1:0] Address,
    output logic [DataLength-1:0]  KeyOut,
    output logic                   NoteStrobe,
    output logic                   EndofScore,
    output logic                   Playing
);

    localparam int PW = (TickDivide > 1) ? $clog2(TickDivide) : 1;
    localparam int GW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [PW-1:0] PTerm = PW'(TickDivide - 1);
    localparam logic [GW-1:0] GTerm = GW'(GapCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP
    } state_t;

    state_t                 r_state, w_state;
    logic [AddressBits-1:0] r_addr, w_addr, w_addr_inc;
    logic [DataLength-1:0]  r_key, w_key;
    logic [TimeBits-1:0]    r_count, w_count;
    logic [PW-1:0]          r_presc, w_presc;
    logic [GW-1:0]          r_gap, w_gap;
    logic                   r_strobe, w_strobe;
    logic                   r_eos, w_eos;

    assign w_addr_inc = r_addr + AddressBits'(1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_key    <= '0;
            r_count  <= '0;
            r_presc  <= '0;
            r_gap    <= '0;
            r_strobe <= 1'b0;
            r_eos    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_addr   <= w_addr;
            r_key    <= w_key;
            r_count  <= w_count;
            r_presc  <= w_presc;
            r_gap    <= w_gap;
            r_strobe <= w_strobe;
            r_eos    <= w_eos;
        end
    end

    // Stop beats Start, Start beats everything the current state would do.
    always_comb begin
        w_state  = r_state;
        w_addr   = r_addr;
        w_key    = r_key;
        w_count  = r_count;
        w_presc  = r_presc;
        w_gap    = r_gap;
        w_strobe = 1'b0;
        w_eos    = 1'b0;
        if (Stop) begin
            w_state = S_IDLE;
            w_addr  = StartAddress;
        end else if (Start) begin
            w_state = S_FETCH;
            w_addr  = StartAddress;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_addr = StartAddress;
                end
                S_FETCH: begin
                    if (KeyInput == '0) begin
                        w_eos  = 1'b1;
                        w_addr = StartAddress;
`ifdef MUSIC_SCORE_LOOP_EN
                        w_state = S_FETCH;
`else
                        w_state = S_IDLE;
`endif
                    end else if (TimeInput == '0) begin
                        w_addr = w_addr_inc;
                    end else begin
                        w_key    = KeyInput;
                        w_count  = TimeInput;
                        w_presc  = '0;
                        w_state  = S_PLAY;
                        w_strobe = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!Pause) begin
                        if (r_presc != PTerm) begin
                            w_presc = r_presc + PW'(1);
                        end else begin
                            w_presc = '0;
                            w_count = r_count - TimeBits'(1);
                            if (r_count == TimeBits'(1)) begin
                                if (GapCycles == 0) begin
                                    w_state = S_FETCH;
                                    w_addr  = w_addr_inc;
                                end else begin
                                    w_state = S_GAP;
                                    w_gap   = '0;
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!Pause) begin
                        if (r_gap != GTerm) begin
                            w_gap = r_gap + GW'(1);
                        end else begin
                            w_gap   = '0;
                            w_state = S_FETCH;
                            w_addr  = w_addr_inc;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign Address    = r_addr;
    assign KeyOut     = (r_state == S_PLAY && !Pause) ? r_key : '0;
    assign NoteStrobe = r_strobe;
    assign EndofScore = r_eos;
    assign Playing    = (r_state != S_IDLE);

endmodule

// File: tb/tb_music_score_sequencer.sv
// Bench for music_score_sequencer: expected per-cycle trace built by walking the score.
module tb_music_score_sequencer;

    localparam int TD   = 4;
    localparam int GAP  = 2;
    localparam int MAXQ = 4000;

    logic       Clock = 1'b0;
    logic       Reset, Start, Stop, Pause;
    logic [4:0] StartAddress;
    logic [3:0] KeyInput, TimeInput;
    logic [4:0] Address;
    logic [3:0] KeyOut;
    logic       NoteStrobe, EndofScore, Playing;

    logic [3:0] mem_key [32];
    logic [3:0] mem_time[32];

    typedef struct {
        logic [3:0] key;
        logic       strobe;
        logic       eos;
        logic       playing;
        logic       pausable;
        logic [4:0] addr;
    } exp_t;

    exp_t       q[$];
    logic [4:0] idle_addr;
    logic [4:0] cur_sa;
    int         total = 0;
    int         bad = 0;

    assign KeyInput  = mem_key[Address];
    assign TimeInput = mem_time[Address];

    always #5 Clock = ~Clock;

    music_score_sequencer #(
        .AddressBits(5),
        .DataLength (4),
        .TimeBits   (4),
        .TickDivide (TD),
        .GapCycles  (GAP)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Stop        (Stop),
        .Pause       (Pause),
        .StartAddress(StartAddress),
        .KeyInput    (KeyInput),
        .TimeInput   (TimeInput),
        .Address     (Address),
        .KeyOut      (KeyOut),
        .NoteStrobe  (NoteStrobe),
        .EndofScore  (EndofScore),
        .Playing     (Playing)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] k, input logic s, input logic e,
                                input logic p, input logic pa, input logic [4:0] a);
        exp_t r;
        r.key = k; r.strobe = s; r.eos = e;
        r.playing = p; r.pausable = pa; r.addr = a;
        return r;
    endfunction

    // Walk the score from sa, laying out every cycle: fetch, note, gap, ...
    task automatic build(input logic [4:0] sa);
        logic [4:0] a;
        logic       pend;
        logic       done;
        int         n;
        q.delete();
        a = sa;
        pend = 1'b0;
        done = 1'b0;
        while (!done && q.size() < MAXQ) begin
            q.push_back(mk(4'd0, 1'b0, pend, 1'b1, 1'b0, a));
            pend = 1'b0;
            if (mem_key[a] == 4'd0) begin
`ifdef MUSIC_SCORE_LOOP_EN
                pend = 1'b1;
                a = sa;
`else
                q.push_back(mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, a));
                done = 1'b1;
`endif
            end else if (mem_time[a] == 4'd0) begin
                a = a + 5'd1;
            end else begin
                n = int'(mem_time[a]) * TD;
                for (int i = 0; i < n; i++)
                    q.push_back(mk(mem_key[a], i == 0, 1'b0, 1'b1, 1'b1, a));
                for (int i = 0; i < GAP; i++)
                    q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, a));
                a = a + 5'd1;
            end
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic ps,
                        input logic rs, input logic nm, input logic [4:0] sa);
        exp_t h;
        @(negedge Clock);
        Start = st;
        Stop = sp;
        Pause = ps;
        Reset = rs;
        StartAddress = sa;
        if (nm) begin
            for (int i = 0; i < 32; i++) begin
                mem_key[i]  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                mem_time[i] = 4'($urandom_range(0, 3));
            end
        end
        #1;
        h = (q.size() > 0) ? q[0] : mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("KeyOut", 32'(KeyOut), 32'((ps && h.pausable) ? 4'd0 : h.key));
        chk("NoteStrobe", 32'(NoteStrobe), 32'(h.strobe));
        chk("EndofScore", 32'(EndofScore), 32'(h.eos));
        chk("Playing", 32'(Playing), 32'(h.playing));
        chk("Address", 32'(Address), 32'(h.playing ? h.addr : idle_addr));
        idle_addr = rs ? 5'd0 : sa;
        if (rs || sp) q.delete();
        else if (st) build(sa);
        else if (ps && h.pausable) q[0].strobe = 1'b0;
        else if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_sa);
    endtask

    task automatic go();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_sa);
    endtask

    task automatic halt();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cur_sa);
    endtask

    task automatic plan_score();
        for (int i = 0; i < 32; i++) begin
            mem_key[i]  = 4'd0;
            mem_time[i] = 4'd0;
        end
        mem_key[3] = 4'd5; mem_time[3] = 4'd2;
        mem_key[4] = 4'd7; mem_time[4] = 4'd1;
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Stop = 1'b0;
        Pause = 1'b0;
        cur_sa = 5'd3;
        StartAddress = cur_sa;
        idle_addr = 5'd0;
        plan_score();
        repeat (2) @(posedge Clock);
        idle(2);

        // full score playback
        go();
        idle(30);

        // pause in the third cycle of key 5
        halt();
        go();
        idle(3);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_sa);
        idle(30);

        // stop inside key 7, then Start together with Stop
        halt();
        go();
        idle(13);
        halt();
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cur_sa);
        idle(3);

        // zero-duration entry is skipped
        halt();
        mem_time[4] = 4'd0;
        go();
        idle(25);

        // address wrap from 31 to 0
        halt();
        mem_key[31] = 4'd3; mem_time[31] = 4'd1;
        mem_key[0]  = 4'd0;
        cur_sa = 5'd31;
        go();
        idle(14);

        // reset mid-note
        halt();
        plan_score();
        cur_sa = 5'd3;
        go();
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cur_sa);
        idle(3);

        for (int c = 0; c < 4000; c++) begin
            int  r;
            logic ps;
            r  = $urandom_range(0, 999);
            ps = ($urandom_range(0, 99) < 15);
            if (q.size() == 0) begin
                if (r < 200) begin
                    cur_sa = 5'($urandom_range(0, 31));
                    step(1'b1, 1'b0, ps, 1'b0, 1'b1, cur_sa);
                end else begin
                    step(1'b0, r < 210, ps, 1'b0, 1'b0, cur_sa);
                end
            end else if (r < 4) begin
                step(1'b0, 1'b0, ps, 1'b1, 1'b0, cur_sa);
            end else if (r < 14) begin
                step(1'b0, 1'b1, ps, 1'b0, 1'b0, cur_sa);
            end else if (r < 24) begin
                cur_sa = 5'($urandom_range(0, 31));
                step(1'b1, 1'b0, ps, 1'b0, 1'b1, cur_sa);
            end else begin
                step(1'b0, 1'b0, ps, 1'b0, 1'b0, cur_sa);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
